// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS ID stage: opcodes, functs, ALU ops and the ID/EX bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluSlt  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluLui  = 4'd7,
    AluPass = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    alu_op_e     alu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] pc_plus_one;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
  } idex_t;

endpackage

// File: rtl/register_file.sv
// 32x32 GPR file: two combinational read ports, one write port, write-back bypass, $0 hardwired.
module register_file #(
  parameter int unsigned DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra_addr,
  input  logic [4:0]  rb_addr,
  output logic [31:0] ra_data,
  output logic [31:0] rb_data,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wen && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // A write landing this cycle is visible to this cycle's reads.
  assign ra_data = (ra_addr == '0) ? '0 :
                   (wen && waddr == ra_addr) ? wdata : regs[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 :
                   (wen && waddr == rb_addr) ? wdata : regs[rb_addr];

endmodule

// File: rtl/instruction_decode.sv
// MIPS ID stage: decode, register read, branch resolution, hazard stall and the ID/EX register.
module instruction_decode
  import mips_pkg::*;
#(
  parameter int unsigned RF_DEPTH = 32,
  parameter int unsigned PC_W     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instruction,
  input  logic [PC_W-1:0] pc_plus_one,
  input  logic            wb_wen,
  input  logic [4:0]      wb_addr,
  input  logic [31:0]     wb_data,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_rd,
  output logic            stall,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_alu_src,
  output logic [3:0]      ex_alu_op,
  output logic [31:0]     ex_rs_data,
  output logic [31:0]     ex_rt_data,
  output logic [31:0]     ex_imm,
  output logic [31:0]     ex_pc_plus_one,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_shamt,
  output logic            illegal
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign funct  = instruction[5:0];
  assign imm16  = instruction[15:0];

  logic [31:0] rs_data, rt_data;

  register_file #(
    .DEPTH(RF_DEPTH)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .ra_addr(rs),
    .rb_addr(rt),
    .ra_data(rs_data),
    .rb_data(rt_data),
    .wen    (wb_wen),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  logic    legal, reg_write, mem_read, mem_write, mem_to_reg, alu_src, zext, rt_src;
  logic    is_br, is_j, is_jal, is_jr;
  alu_op_e alu_op;
  logic [4:0] dest;

  always_comb begin
    legal = 1'b1; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
    alu_src = 1'b0; zext = 1'b0; rt_src = 1'b0; alu_op = AluAdd; dest = rt;
    is_br = 1'b0; is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_write = 1'b1; rt_src = 1'b1; dest = rd;
        case (funct)
          FN_ADD: alu_op = AluAdd;
          FN_SUB: alu_op = AluSub;
          FN_AND: alu_op = AluAnd;
          FN_OR:  alu_op = AluOr;
          FN_SLT: alu_op = AluSlt;
          FN_SLL: alu_op = AluSll;
          FN_SRL: alu_op = AluSrl;
          FN_JR:  begin reg_write = 1'b0; rt_src = 1'b0; is_jr = 1'b1; end
          default: begin legal = 1'b0; rt_src = 1'b0; end
        endcase
      end
      OP_ADDI: begin reg_write = 1'b1; alu_src = 1'b1; end
      OP_SLTI: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = AluSlt; end
      OP_ANDI: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = AluAnd; zext = 1'b1; end
      OP_ORI:  begin reg_write = 1'b1; alu_src = 1'b1; alu_op = AluOr;  zext = 1'b1; end
      OP_LUI:  begin reg_write = 1'b1; alu_src = 1'b1; alu_op = AluLui; zext = 1'b1; end
      OP_LW:   begin reg_write = 1'b1; alu_src = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; end
      OP_SW:   begin alu_src = 1'b1; mem_write = 1'b1; rt_src = 1'b1; end
      OP_BEQ, OP_BNE: begin is_br = 1'b1; rt_src = 1'b1; end
      OP_J:    is_j = 1'b1;
      OP_JAL:  begin
        is_jal = 1'b1; reg_write = 1'b1; alu_src = 1'b1; alu_op = AluPass; dest = REG_RA;
      end
      default: legal = 1'b0;
    endcase
  end

  idex_t idex_q, idex_d;
  logic  squash_q, illegal_q;

  function automatic logic fwd_hit(logic [4:0] src, logic ex_w, logic [4:0] ex_d,
                                   logic mem_w, logic [4:0] mem_d);
    return (ex_w && ex_d != '0 && ex_d == src) || (mem_w && mem_d != '0 && mem_d == src);
  endfunction

  logic load_use, branch_haz, taken, issue;
  logic [31:0] imm_ext;

  always_comb begin
    load_use = idex_q.valid && idex_q.mem_read && idex_q.rd != '0 &&
               (idex_q.rd == rs || (rt_src && idex_q.rd == rt));
    // Branch operands are compared in ID, so any in-flight producer must drain first.
    branch_haz = ((is_br || is_jr) &&
                  fwd_hit(rs, idex_q.reg_write, idex_q.rd, mem_reg_write, mem_rd)) ||
                 (is_br && fwd_hit(rt, idex_q.reg_write, idex_q.rd, mem_reg_write, mem_rd));
    stall    = !squash_q && (load_use || branch_haz);
    taken    = is_br && ((rs_data == rt_data) != (opcode == OP_BNE));
    redirect = !squash_q && !stall && (taken || is_j || is_jal || is_jr);
    imm_ext  = zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
    if (is_jr) begin
      redirect_pc = rs_data;
    end else if (is_j || is_jal) begin
      redirect_pc = {pc_plus_one[PC_W-1:26], instruction[25:0]};
    end else begin
      redirect_pc = pc_plus_one + imm_ext;
    end
  end

  assign issue = !squash_q && !stall && legal;

  // Non-writing instructions carry rd=0 so downstream never matches them as producers.
  always_comb begin
    idex_d = '0;
    if (issue) begin
      idex_d.valid       = 1'b1;
      idex_d.reg_write   = reg_write;
      idex_d.mem_read    = mem_read;
      idex_d.mem_write   = mem_write;
      idex_d.mem_to_reg  = mem_to_reg;
      idex_d.alu_src     = alu_src;
      idex_d.alu_op      = alu_op;
      idex_d.rs_data     = rs_data;
      idex_d.rt_data     = rt_data;
      idex_d.imm         = is_jal ? pc_plus_one : imm_ext;
      idex_d.pc_plus_one = pc_plus_one;
      idex_d.rs          = rs;
      idex_d.rt          = rt;
      idex_d.rd          = reg_write ? dest : 5'd0;
      idex_d.shamt       = instruction[10:6];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q    <= '0;
      illegal_q <= 1'b0;
      squash_q  <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      illegal_q <= !squash_q && !stall && !legal;
      squash_q  <= redirect;
    end
  end

  assign ex_valid       = idex_q.valid;
  assign ex_reg_write   = idex_q.reg_write;
  assign ex_mem_read    = idex_q.mem_read;
  assign ex_mem_write   = idex_q.mem_write;
  assign ex_mem_to_reg  = idex_q.mem_to_reg;
  assign ex_alu_src     = idex_q.alu_src;
  assign ex_alu_op      = idex_q.alu_op;
  assign ex_rs_data     = idex_q.rs_data;
  assign ex_rt_data     = idex_q.rt_data;
  assign ex_imm         = idex_q.imm;
  assign ex_pc_plus_one = idex_q.pc_plus_one;
  assign ex_rs          = idex_q.rs;
  assign ex_rt          = idex_q.rt;
  assign ex_rd          = idex_q.rd;
  assign ex_shamt       = idex_q.shamt;
  assign illegal        = illegal_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed vector table plus random stimulus against a mnemonic-level model.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction, pc_plus_one, wb_data, redirect_pc;
  logic        wb_wen, mem_reg_write, stall, redirect;
  logic [4:0]  wb_addr, mem_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus_one;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
  logic        illegal;

  instruction_decode dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .pc_plus_one(pc_plus_one),
    .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_pc_plus_one(ex_pc_plus_one), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_shamt(ex_shamt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
    logic [3:0]  alu_op;
    logic [31:0] rs_data, rt_data, imm, pc1;
    logic [4:0]  rs, rt, rd, shamt;
  } ex_t;

  typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_SRL, M_JR, M_ADDI, M_ANDI, M_ORI,
                M_SLTI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JAL, M_BAD} mn_e;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0] m_rf [32];
  ex_t         m_ex;
  logic        m_ill, m_sq;
  // Model predictions for the current cycle
  logic        e_stall, e_redir, e_ill;
  logic [31:0] e_rpc;
  ex_t         e_next;
  // Captured combinational outputs for the directed table
  logic        cmb_stall, cmb_redir;
  logic [31:0] cmb_rpc;

  task automatic chk(string name, logic [191:0] act, logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic mn_e classify(logic [31:0] ins);
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: return M_ADD;  6'h22: return M_SUB;  6'h24: return M_AND;
        6'h25: return M_OR;   6'h2A: return M_SLT;  6'h00: return M_SLL;
        6'h02: return M_SRL;  6'h08: return M_JR;
        default: return M_BAD;
      endcase
      6'h08: return M_ADDI; 6'h0C: return M_ANDI; 6'h0D: return M_ORI;
      6'h0A: return M_SLTI; 6'h0F: return M_LUI;  6'h23: return M_LW;
      6'h2B: return M_SW;   6'h04: return M_BEQ;  6'h05: return M_BNE;
      6'h02: return M_J;    6'h03: return M_JAL;
      default: return M_BAD;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(mn_e m);
    case (m)
      M_SUB: return 4'd1;
      M_AND, M_ANDI: return 4'd2;
      M_OR, M_ORI: return 4'd3;
      M_SLT, M_SLTI: return 4'd4;
      M_SLL: return 4'd5;
      M_SRL: return 4'd6;
      M_LUI: return 4'd7;
      M_JAL: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] rf_read(logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_wen && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic bit producer(logic [4:0] r);
    return (m_ex.reg_write && m_ex.rd != 0 && m_ex.rd == r) ||
           (mem_reg_write && mem_rd != 0 && mem_rd == r);
  endfunction

  task automatic model_eval();
    mn_e m = classify(instruction);
    logic [4:0] f_rs = instruction[25:21];
    logic [4:0] f_rt = instruction[20:16];
    logic [31:0] a = rf_read(f_rs);
    logic [31:0] b = rf_read(f_rt);
    logic [31:0] sx = {{16{instruction[15]}}, instruction[15:0]};
    bit writes = m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_SRL, M_ADDI, M_ANDI,
                           M_ORI, M_SLTI, M_LUI, M_LW, M_JAL};
    bit rt_used = m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_SRL, M_SW, M_BEQ, M_BNE};
    bit is_b = m inside {M_BEQ, M_BNE};
    bit lu = m_ex.valid && m_ex.mem_read && m_ex.rd != 0 &&
             (m_ex.rd == f_rs || (rt_used && m_ex.rd == f_rt));
    bit bh = ((is_b || m == M_JR) && producer(f_rs)) || (is_b && producer(f_rt));
    bit tk = (m == M_BEQ && a == b) || (m == M_BNE && a != b);
    e_stall = !m_sq && (lu || bh);
    e_redir = !m_sq && !e_stall && (tk || m inside {M_J, M_JAL, M_JR});
    if (m == M_JR) e_rpc = a;
    else if (m inside {M_J, M_JAL}) e_rpc = {pc_plus_one[31:26], instruction[25:0]};
    else e_rpc = pc_plus_one + sx;
    e_ill = !m_sq && !e_stall && m == M_BAD;
    e_next = '0;
    if (!m_sq && !e_stall && m != M_BAD) begin
      e_next.valid = 1'b1;
      e_next.reg_write = writes;
      e_next.mem_read = (m == M_LW);
      e_next.mem_to_reg = (m == M_LW);
      e_next.mem_write = (m == M_SW);
      e_next.alu_src = m inside {M_ADDI, M_ANDI, M_ORI, M_SLTI, M_LUI, M_LW, M_SW, M_JAL};
      e_next.alu_op = alu_of(m);
      e_next.rs_data = a;
      e_next.rt_data = b;
      if (m == M_JAL) e_next.imm = pc_plus_one;
      else if (m inside {M_ANDI, M_ORI, M_LUI}) e_next.imm = {16'd0, instruction[15:0]};
      else e_next.imm = sx;
      e_next.pc1 = pc_plus_one;
      e_next.rs = f_rs;
      e_next.rt = f_rt;
      if (!writes) e_next.rd = 5'd0;
      else if (m == M_JAL) e_next.rd = 5'd31;
      else if (m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_SRL})
        e_next.rd = instruction[15:11];
      else e_next.rd = f_rt;
      e_next.shamt = instruction[10:6];
    end
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      m_ex = '0; m_ill = 1'b0; m_sq = 1'b0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else begin
      m_ex = e_next; m_ill = e_ill; m_sq = e_redir;
      if (wb_wen && wb_addr != 0) m_rf[wb_addr] = wb_data;
    end
  endtask

  function automatic ex_t act_ex();
    return {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
            ex_alu_op, ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus_one, ex_rs, ex_rt, ex_rd,
            ex_shamt};
  endfunction

  task automatic tick();
    @(negedge clk);
    model_eval();
    cmb_stall = stall; cmb_redir = redirect; cmb_rpc = redirect_pc;
    if (rst_n) begin
      chk("stall", stall, e_stall);
      chk("redirect", redirect, e_redir);
      if (e_redir) chk("redirect_pc", redirect_pc, e_rpc);
    end
    @(posedge clk);
    model_commit();
    #1;
    chk("ex_bundle", act_ex(), m_ex);
    chk("illegal", illegal, m_ill);
  endtask

  function automatic logic [31:0] rand_instr();
    int k = $urandom_range(0, 20);
    logic [4:0] a = 5'($urandom_range(0, 7));
    logic [4:0] b = 5'($urandom_range(0, 7));
    logic [4:0] c = 5'($urandom_range(0, 7));
    logic [4:0] sh = 5'($urandom);
    logic [15:0] im = 16'($urandom);
    logic [25:0] tg = 26'($urandom);
    case (k)
      0: return {6'h00, a, b, c, sh, 6'h20};
      1: return {6'h00, a, b, c, sh, 6'h22};
      2: return {6'h00, a, b, c, sh, 6'h24};
      3: return {6'h00, a, b, c, sh, 6'h25};
      4: return {6'h00, a, b, c, sh, 6'h2A};
      5: return {6'h00, a, b, c, sh, 6'h00};
      6: return {6'h00, a, b, c, sh, 6'h02};
      7: return {6'h00, a, b, c, sh, 6'h08};
      8: return {6'h08, a, b, im};
      9: return {6'h0C, a, b, im};
      10: return {6'h0D, a, b, im};
      11: return {6'h0A, a, b, im};
      12: return {6'h0F, a, b, im};
      13: return {6'h23, a, b, im};
      14: return {6'h2B, a, b, im};
      15: return {6'h04, a, b, im};
      16: return {6'h05, a, b, im};
      17: return {6'h02, tg};
      18: return {6'h03, tg};
      19: return {6'h3F, tg};
      default: return {6'h00, a, b, c, sh, 6'h21};
    endcase
  endfunction

  typedef struct {
    logic [31:0] instr, pc1;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        mrw;
    logic [4:0]  mrd;
    logic        x_stall, x_redir;
    logic [31:0] x_rpc;
    logic        x_valid;
    logic [4:0]  x_rd;
    logic [31:0] x_imm, x_rsd;
    logic        x_ill;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{32'h00A53820, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h3820, 0, 0});
    vecs.push_back('{32'h2064FFFF, 32'h101, 1, 3, 32'h1234, 0, 0, 0, 0, 0, 1, 4,
                     32'hFFFFFFFF, 32'h1234, 0});
    vecs.push_back('{32'h8C220000, 32'h102, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0});
    vecs.push_back('{32'h00422820, 32'h103, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{32'h00422820, 32'h103, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h2820, 0, 0});
    vecs.push_back('{32'h10210004, 32'h10, 0, 0, 0, 0, 0, 0, 1, 32'h14, 1, 0, 4, 0, 0});
    vecs.push_back('{32'h00400008, 32'h11, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{32'h2064FFFF, 32'h14, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4,
                     32'hFFFFFFFF, 32'h1234, 0});
    vecs.push_back('{32'h0C000040, 32'h21, 0, 0, 0, 0, 0, 0, 1, 32'h40, 1, 31, 32'h21, 0, 0});
    vecs.push_back('{32'hFC000000, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{32'h201F0007, 32'h41, 0, 0, 0, 0, 0, 0, 0, 0, 1, 31, 7, 0, 0});
    vecs.push_back('{32'h03E00008, 32'h42, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{32'h03E00008, 32'h42, 1, 31, 32'h77, 0, 0, 0, 1, 32'h77, 1, 0, 8,
                     32'h77, 0});
    vecs.push_back('{32'h2064FFFF, 32'h43, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{32'h00003020, 32'h78, 1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 1, 6, 32'h3020, 0, 0});
    vecs.push_back('{32'h00003020, 32'h78, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h3020, 0, 0});
    vecs.push_back('{32'hFC000000, 32'h79, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{32'h2064FFFF, 32'h7A, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4,
                     32'hFFFFFFFF, 32'h1234, 0});

    // Reset with garbage on every input, including a write to $5.
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      instruction = $urandom; pc_plus_one = $urandom; wb_wen = 1'b1; wb_addr = 5'd5;
      wb_data = 32'hDEADBEEF; mem_reg_write = 1'b1; mem_rd = 5'($urandom);
      tick();
      chk("reset_bundle", act_ex(), '0);
    end
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      instruction = vecs[i].instr; pc_plus_one = vecs[i].pc1;
      wb_wen = vecs[i].wen; wb_addr = vecs[i].waddr; wb_data = vecs[i].wdata;
      mem_reg_write = vecs[i].mrw; mem_rd = vecs[i].mrd;
      tick();
      chk($sformatf("v%0d_stall", i), cmb_stall, vecs[i].x_stall);
      chk($sformatf("v%0d_redirect", i), cmb_redir, vecs[i].x_redir);
      if (vecs[i].x_redir) chk($sformatf("v%0d_redirect_pc", i), cmb_rpc, vecs[i].x_rpc);
      chk($sformatf("v%0d_ex_valid", i), ex_valid, vecs[i].x_valid);
      chk($sformatf("v%0d_ex_rd", i), ex_rd, vecs[i].x_rd);
      chk($sformatf("v%0d_ex_imm", i), ex_imm, vecs[i].x_imm);
      chk($sformatf("v%0d_ex_rs_data", i), ex_rs_data, vecs[i].x_rsd);
      chk($sformatf("v%0d_illegal", i), illegal, vecs[i].x_ill);
    end

    for (int i = 0; i < 3000; i++) begin
      rst_n = (i % 700 != 699);
      instruction = rand_instr();
      pc_plus_one = $urandom;
      wb_wen = 1'($urandom); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      mem_reg_write = 1'($urandom); mem_rd = 5'($urandom_range(0, 7));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- ID stage of the 5-stage word-addressed MIPS pipeline; directly downstream of instruction fetch.
- Decodes the fetched word and reads the 32x32 register file (WB write port included).
- Resolves branches/jumps in ID; detects load-use and branch-operand hazards.
- Drives the registered ID/EX pipeline bundle consumed by execute; returns stall and redirect to fetch.

Parameters:
- RF_DEPTH, 32, number of GPRs (fixed at 32 for MIPS; 5-bit indices).
- PC_W, 32, PC width (word address).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- instruction  in  32  word fetched last cycle
- pc_plus_one  in  32  word address of instruction, plus 1
- wb_wen  in  1  WB register write enable
- wb_addr  in  5  WB destination
- wb_data  in  32  WB data
- mem_reg_write  in  1  instruction in MEM writes a register
- mem_rd  in  5  its destination
- stall  out  1  combinational; fetch holds PC and instruction
- redirect  out  1  combinational; fetch loads redirect_pc next edge
- redirect_pc  out  32  branch/jump target
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1 each  registered control
- ex_alu_op  out  4  registered ALU op
- ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus_one  out  32 each  registered data
- ex_rs, ex_rt, ex_rd  out  5 each  registered indices (ex_rd = final destination)
- ex_shamt  out  5  shift amount
- illegal  out  1  registered; unsupported opcode/funct decoded (bubble issued)

Behaviour:
- Reset (rst_n=0 at edge): all ex_* outputs, illegal, squash flag and all 32 GPRs cleared to 0.
- Supported instructions: add, sub, and, or, slt, sll, srl, jr, addi, andi, ori, slti, lui, lw, sw, beq, bne, j, jal.
- Anything else: bubble, illegal=1 for one cycle.
- Immediate extension: andi, ori and lui zero-extend; all others sign-extend.
- Destination: R-type uses rd; I-type uses rt; jal uses 31.
- jal writes pc_plus_one through the ALU path: ex_alu_op=PASS, ex_imm=pc_plus_one, ex_alu_src=1.
- Register file:
  - Combinational read.
  - Writes at the clock edge when wb_wen=1 and wb_addr!=0.
  - $0 always reads 0.
  - Same-cycle bypass: if wb_wen=1 and wb_addr==src!=0, the read returns wb_data.
- Hazards (stall=1):
  - (a) Load-use: ex_valid, ex_mem_read, and ex_rd!=0 equals rs, or equals rt where rt is a source.
  - (b) beq/bne/jr source equals ex_rd (ex_reg_write, ex_rd!=0) or mem_rd (mem_reg_write, mem_rd!=0).
  - While stalled, ID/EX loads a bubble (all control 0, ex_valid=0); the RF write still occurs; redirect=0.
- Control flow (only when not stalled and not squashed):
  - beq taken if rs_data==rt_data; bne taken if unequal.
  - Taken branch: redirect_pc = pc_plus_one + sext(imm16), mod 2^32.
  - j/jal: redirect_pc = {pc_plus_one[31:26], instr[25:0]}.
  - jr: redirect_pc = rs_data.
  - redirect=1 for exactly that cycle.
- Squash: when redirect=1, set squash flag at the edge. Next cycle's instruction (wrong path) becomes a bubble: no stall, no redirect. Flag then clears.
- Simultaneous events: stall has priority over redirect. A squashed slot never asserts stall. Reset overrides all.
- Branches, j, jr and sw issue with ex_reg_write=0. jal issues with ex_reg_write=1.

Decomposition:
- Package mips_pkg:
  - opcode and funct localparams.
  - ALU op encoding: ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5, SRL=6, LUI=7, PASS=8.
  - REG_RA=31.
- Sub-module register_file: 2 read ports, 1 write port, WB bypass, synchronous reset.
- Decode, hazard and ID/EX register logic stay in instruction_decode.

Test Plan:
- Reset with garbage inputs -> all ex_* = 0; reading $5 returns 0.
- wb_wen=1, wb_addr=3, wb_data=0x1234 while decoding addi $4,$3,-1 -> next cycle ex_rs_data=0x1234, ex_imm=0xFFFFFFFF, ex_rd=4, ex_alu_op=ADD, ex_alu_src=1.
- lw $2,0($1) then add $5,$2,$2 -> stall=1 for one cycle, one bubble (ex_valid=0), then add issues.
- beq $1,$1,+4 at pc_plus_one=0x10 -> redirect=1, redirect_pc=0x14; next instruction squashed (ex_valid=0); the one after decodes normally.
- jal with target field 0x40 -> redirect_pc=0x40; ex_rd=31, ex_imm=pc_plus_one; then jr $31 with addi $31 in EX -> stall 1, then redirect_pc=rs_data.
- WB to $0 with 0xFFFF -> $0 still reads 0; opcode 0x3F -> illegal=1, bubble issued.
